mult32x32_fast_fsm: RTL and testbench
=====================================

// Module: mult32x32_fast_fsm
// PURPOSE
//  Control FSM for the 32x32 fast multiplier; drives the arithmetic unit's select/update/clear strobes.
//  Sequences up to four 16x16 partial products (A0B0, A0B1, A1B0, A1B1) into the product register.
//  Skips partial products whose operand MSW is zero, using a_msw_is_0 / b_msw_is_0 from the datapath.
//  Upstream sees a start/busy/done handshake.
// PARAMETERS
//  SKIP_EN  1  1: skip zero-MSW partial products; 0: always run all four (slow reference mode)
//  CNT_W    3  width of op_cycles perf counter (must hold value 4)
// PORTS
//  clk         in   1      clock, all state updates on posedge
//  reset       in   1      synchronous, active-low reset (0 = reset, sampled on posedge clk)
//  start       in   1      request new multiply; honoured only in IDLE
//  a_msw_is_0  in   1      from arith unit: a[31:16]==0
//  b_msw_is_0  in   1      from arith unit: b[31:16]==0
//  busy        out  1      high in any update state (A0B0..A1B1)
//  done        out  1      one-cycle pulse; product register final in this cycle
//  a_sel       out  1      0: a[15:0], 1: a[31:16]
//  b_sel       out  1      0: b[15:0], 1: b[31:16]
//  shift_sel   out  2      0: <<0, 1: <<16, 2: <<32 (3 never driven)
//  upd_prod    out  1      accumulate shifted partial product this cycle
//  clr_prod    out  1      clear product register this cycle
//  op_cycles   out  CNT_W  number of update states executed by last/current op
// BEHAVIOUR
//  States: IDLE, A0B0, A0B1, A1B0, A1B1, DONE. Next-state and op_cycles registered; strobes combinational.
//  Reset (reset==0 at posedge): state=IDLE, op_cycles=0. Reset wins over start and overrides mid-op.
//  Outputs in reset/IDLE: busy=0, done=0, a_sel=0, b_sel=0, shift_sel=0, upd_prod=0.
//  IDLE: clr_prod = start (Mealy). If start=1 -> A0B0, op_cycles<=0.
//  Update states drive upd_prod=1, busy=1, clr_prod=0, and the per-state selects:
//    A0B0 a_sel=0 b_sel=0 shift=0
//    A0B1 a_sel=0 b_sel=1 shift=1
//    A1B0 a_sel=1 b_sel=0 shift=1
//    A1B1 a_sel=1 b_sel=1 shift=2
//  Each update state increments op_cycles by 1.
//  Transitions (SKIP_EN=1; flags sampled combinationally in current state):
//    A0B0 -> A0B1 if !b_msw_is_0, else A1B0 if !a_msw_is_0, else DONE
//    A0B1 -> A1B0 if !a_msw_is_0, else DONE (b MSW nonzero, a MSW zero => A1B1 also zero)
//    A1B0 -> A1B1 if !b_msw_is_0, else DONE
//    A1B1 -> DONE
//  SKIP_EN=0: fixed order A0B0->A0B1->A1B0->A1B1->DONE; flags ignored.
//  DONE: done=1, busy=0, upd_prod=0, clr_prod=0; always -> IDLE next cycle.
//  op_cycles holds its value from DONE until the next accepted start.
//  Handshake and timing:
//    start outside IDLE (incl. DONE) is ignored, with no queuing.
//    Operands a,b must be held stable from the start cycle through DONE.
//    Latency: start accepted at cycle T; done at T+1+N, where N = op_cycles (1..4).
//  A start pulse wider than 1 cycle does not retrigger; a re-assert is accepted on the first IDLE cycle after DONE.
//  Reset mid-op: the FSM returns to IDLE. The arith product register is not cleared by this block except via clr_prod on the next start.
// TESTING
//  a=0x0000_1234, b=0x0000_5678, start@T -> clr@T, one upd (A0B0) @T+1; done@T+2, op_cycles=1, product=0x0626_0060
//  a=0x0001_0000, b=0x0000_0003 -> states A0B0, A1B0; done@T+3; op_cycles=2; product=0x3_0000
//  a=0xFFFF_FFFF, b=0xFFFF_FFFF -> all four states with shift 0,1,1,2; done@T+5; op_cycles=4; product=0xFFFF_FFFE_0000_0001
//  SKIP_EN=0, a=b=0 -> four upd cycles; done@T+5; op_cycles=4; product=0
//  start held high 8 cycles with a=b=0x0000_0002 -> two ops back-to-back: done@T+2, next clr@T+3, done@T+5
//  reset=0 during A0B1 -> next cycle IDLE, busy=0, upd_prod=0, op_cycles=0; a following start runs a clean op

Source files
------------

// File: rtl/mult32x32_fast_fsm.sv
// Control FSM for the 32x32 fast multiplier: sequences up to four 16x16 partial
// products into the arith unit's product register, skipping zero-MSW terms.
module mult32x32_fast_fsm #(
  parameter bit SKIP_EN = 1'b1,
  parameter int CNT_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a_msw_is_0,
  input  logic             b_msw_is_0,
  output logic             busy,
  output logic             done,
  output logic             a_sel,
  output logic             b_sel,
  output logic [1:0]       shift_sel,
  output logic             upd_prod,
  output logic             clr_prod,
  output logic [CNT_W-1:0] op_cycles
);

  typedef enum logic [2:0] {
    IDLE,
    A0B0,
    A0B1,
    A1B0,
    A1B1,
    DONE
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        op_cycles <= '0;
      end else if (upd_prod) begin
        op_cycles <= op_cycles + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = 2'd0;
    upd_prod  = 1'b0;
    clr_prod  = 1'b0;
    case (state)
      IDLE: begin
        clr_prod = start;
        if (start) state_nxt = A0B0;
      end
      A0B0: begin
        busy     = 1'b1;
        upd_prod = 1'b1;
        if (!SKIP_EN || !b_msw_is_0) state_nxt = A0B1;
        else if (!a_msw_is_0)        state_nxt = A1B0;
        else                         state_nxt = DONE;
      end
      A0B1: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'd1;
        // b MSW is nonzero here, so a zero a MSW makes both A1 terms zero
        if (!SKIP_EN || !a_msw_is_0) state_nxt = A1B0;
        else                         state_nxt = DONE;
      end
      A1B0: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        shift_sel = 2'd1;
        if (!SKIP_EN || !b_msw_is_0) state_nxt = A1B1;
        else                         state_nxt = DONE;
      end
      A1B1: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = 2'd2;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult32x32_fast_fsm.sv
// Bench for mult32x32_fast_fsm: two instances (skip / no-skip) each driving a
// small product-register model; directed vector table plus corner sequences.
module tb_mult32x32_fast_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        a_msw_is_0, b_msw_is_0;

  assign a_msw_is_0 = (a[31:16] == 16'h0);
  assign b_msw_is_0 = (b[31:16] == 16'h0);

  always #5 clk = ~clk;

  logic       busy_f, done_f, asel_f, bsel_f, upd_f, clr_f;
  logic [1:0] sh_f;
  logic [2:0] opc_f;
  logic       busy_s, done_s, asel_s, bsel_s, upd_s, clr_s;
  logic [1:0] sh_s;
  logic [2:0] opc_s;

  mult32x32_fast_fsm #(.SKIP_EN(1'b1), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_msw_is_0(a_msw_is_0), .b_msw_is_0(b_msw_is_0),
    .busy(busy_f), .done(done_f), .a_sel(asel_f), .b_sel(bsel_f),
    .shift_sel(sh_f), .upd_prod(upd_f), .clr_prod(clr_f), .op_cycles(opc_f)
  );

  mult32x32_fast_fsm #(.SKIP_EN(1'b0), .CNT_W(3)) dut_slow (
    .clk(clk), .reset(reset), .start(start),
    .a_msw_is_0(a_msw_is_0), .b_msw_is_0(b_msw_is_0),
    .busy(busy_s), .done(done_s), .a_sel(asel_s), .b_sel(bsel_s),
    .shift_sel(sh_s), .upd_prod(upd_s), .clr_prod(clr_s), .op_cycles(opc_s)
  );

  // Arith-unit product register model, one per instance
  logic [63:0] prod_f = '0, prod_s = '0;

  function automatic logic [63:0] pp(input logic [31:0] x, input logic [31:0] y,
                                     input logic xs, input logic ys, input logic [1:0] sh);
    logic [15:0] xh, yh;
    logic [63:0] p;
    xh = xs ? x[31:16] : x[15:0];
    yh = ys ? y[31:16] : y[15:0];
    p  = 64'(32'(xh) * 32'(yh));
    return p << (16 * int'(sh));
  endfunction

  always @(posedge clk) begin
    if (clr_f) prod_f <= '0;
    else if (upd_f) prod_f <= prod_f + pp(a, b, asel_f, bsel_f, sh_f);
    if (clr_s) prod_s <= '0;
    else if (upd_s) prod_s <= prod_s + pp(a, b, asel_s, bsel_s, sh_s);
  end

  // Observation mux selects which instance a table vector checks
  logic        use_slow = 1'b0;
  logic        m_busy, m_done, m_asel, m_bsel, m_upd, m_clr;
  logic [1:0]  m_sh;
  logic [2:0]  m_opc;
  logic [63:0] m_prod;
  assign m_busy = use_slow ? busy_s : busy_f;
  assign m_done = use_slow ? done_s : done_f;
  assign m_asel = use_slow ? asel_s : asel_f;
  assign m_bsel = use_slow ? bsel_s : bsel_f;
  assign m_upd  = use_slow ? upd_s  : upd_f;
  assign m_clr  = use_slow ? clr_s  : clr_f;
  assign m_sh   = use_slow ? sh_s   : sh_f;
  assign m_opc  = use_slow ? opc_s  : opc_f;
  assign m_prod = use_slow ? prod_s : prod_f;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // seq: per update step k, nibble k = {a_sel, b_sel, shift_sel}
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        slow;
    int          n;
    logic [15:0] seq;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k;
    use_slow = v.slow;
    @(negedge clk);
    a = v.a;
    b = v.b;
    start = 1'b1;
    #1;
    chk($sformatf("v%0d clr_on_start", idx), 64'(m_clr), 64'(1));
    chk($sformatf("v%0d idle_busy", idx), 64'(m_busy), 64'(0));
    @(negedge clk);
    start = 1'b0;
    #1;
    k = 0;
    while (!m_done && k < 6) begin
      chk($sformatf("v%0d step%0d sel", idx, k),
          64'({m_asel, m_bsel, m_sh}), 64'(v.seq[4*(k%4) +: 4]));
      chk($sformatf("v%0d step%0d upd_busy", idx, k),
          64'({m_upd, m_busy, m_clr}), 64'(3'b110));
      k++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("v%0d done", idx), 64'(m_done), 64'(1));
    chk($sformatf("v%0d latency_updates", idx), 64'(k), 64'(v.n));
    chk($sformatf("v%0d op_cycles", idx), 64'(m_opc), 64'(v.n));
    chk($sformatf("v%0d done_strobes", idx), 64'({m_busy, m_upd, m_clr}), 64'(0));
    chk($sformatf("v%0d product", idx), m_prod, v.prod);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d done_one_cycle", idx), 64'(m_done), 64'(0));
    chk($sformatf("v%0d op_cycles_hold", idx), 64'(m_opc), 64'(v.n));
  endtask

  logic [7:0] exp_clr, exp_done;

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h0000_5678, 1'b0, 1, 16'h0000, 64'h0000_0000_0626_0060};
    vecs[1] = '{32'h0001_0000, 32'h0000_0003, 1'b0, 2, 16'h0090, 64'h0000_0000_0003_0000};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4, 16'hE950, 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 4, 16'hE950, 64'h0};
    vecs[4] = '{32'h0000_0003, 32'h0002_0000, 1'b0, 2, 16'h0050, 64'h0000_0000_0006_0000};
    vecs[5] = '{32'h0002_0000, 32'h0003_0000, 1'b0, 4, 16'hE950, 64'h0000_0006_0000_0000};
    vecs[6] = '{32'h0001_0001, 32'h0001_0001, 1'b0, 4, 16'hE950, 64'h0000_0001_0002_0001};
    vecs[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1, 16'h0000, 64'h0};

    // Reset state, with start asserted to show reset wins
    reset = 1'b0;
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_outputs", 64'({busy_f, done_f, asel_f, bsel_f, sh_f, upd_f}), 64'(0));
    chk("reset_op_cycles", 64'(opc_f), 64'(0));
    chk("reset_slow_outputs", 64'({busy_s, done_s, upd_s, opc_s}), 64'(0));
    start = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_vec(vecs[i], i);
    end

    // Start held for 8 cycles: back-to-back ops, no retrigger in DONE
    use_slow = 1'b0;
    do_reset();
    exp_clr  = 8'b0100_1001;
    exp_done = 8'b0010_0100;
    @(negedge clk);
    a = 32'h0000_0002;
    b = 32'h0000_0002;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("held c%0d clr", c), 64'(clr_f), 64'(exp_clr[c]));
      chk($sformatf("held c%0d done", c), 64'(done_f), 64'(exp_done[c]));
      if (c == 2) chk("held first_product", prod_f, 64'd4);
      @(negedge clk);
    end
    start = 1'b0;

    // Reset during A0B1 returns to IDLE and clears op_cycles
    do_reset();
    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("midop in_A0B1", 64'({busy_f, asel_f, bsel_f, sh_f}), 64'(5'b1_0_1_01));
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midop idle_strobes", 64'({busy_f, upd_f, done_f}), 64'(0));
    chk("midop op_cycles", 64'(opc_f), 64'(0));
    @(negedge clk);
    #1;
    chk("midop stays_idle", 64'({busy_f, upd_f}), 64'(0));
    run_vec(vecs[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
